// File: rtl/mem_port_adapter_pkg.sv
// mem_port_adapter_pkg: shared size/sign encodings and FSM states for the memory port adapter.
package mem_port_adapter_pkg;
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;
    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_port_state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: maps byte offset and size/sign onto word lanes, extends load data, flags bad requests.
module mem_lane_align
    import mem_port_adapter_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        bad
);
    logic [3:0]  base;
    logic [31:0] sh;
    assign sh         = rdata >> {offset, 3'b000};
    assign wmask      = write ? base << offset : 4'b0000;
    assign wdata_lane = write ? wdata << {offset, 3'b000} : 32'd0;
    always_comb begin
        base      = 4'b0000;
        bad       = 1'b1;
        rdata_ext = 32'd0;
        case (funct3)
            LB:  begin base = 4'b0001; bad = 1'b0;      rdata_ext = {{24{sh[7]}}, sh[7:0]}; end
            LBU: begin base = 4'b0001; bad = 1'b0;      rdata_ext = {24'd0, sh[7:0]}; end
            LH:  begin base = 4'b0011; bad = offset[0]; rdata_ext = {{16{sh[15]}}, sh[15:0]}; end
            LHU: begin base = 4'b0011; bad = offset[0]; rdata_ext = {16'd0, sh[15:0]}; end
            LW:  begin base = 4'b1111; bad = |offset;   rdata_ext = sh; end
            default: ;
        endcase
        if (write && !(funct3 inside {SB, SH, SW})) bad = 1'b1;
    end
endmodule

// File: rtl/mem_port_adapter.sv
// mem_port_adapter: turns one byte/half/word load or store into an aligned, masked word access with timeout.
module mem_port_adapter
    import mem_port_adapter_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    mem_port_state_t state;
    logic [1:0]      off;
    logic [2:0]      f3;
    logic            wr;
    logic [CW-1:0]   cnt;
    logic [3:0]      wmask;
    logic [31:0]     wdata_lane, rdata_ext;
    logic            bad;
    // In IDLE the aligner looks at the live request; afterwards at the latched one for load data.
    mem_lane_align u_align (
        .offset     (state == IDLE ? req_addr[1:0] : off),
        .funct3     (state == IDLE ? req_funct3 : f3),
        .write      (state == IDLE ? req_write : wr),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .wmask      (wmask),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .bad        (bad)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= 32'd0;
            mem_address <= 32'd0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_wmask   <= 4'd0;
            mem_wdata   <= 32'd0;
            off         <= 2'd0;
            f3          <= 3'd0;
            wr          <= 1'b0;
            cnt         <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        off         <= req_addr[1:0];
                        f3          <= req_funct3;
                        wr          <= req_write;
                        req_ready   <= 1'b0;
                        resp_rdata  <= 32'd0;
                        resp_err    <= bad;
                        cnt         <= '0;
                        mem_address <= {req_addr[31:2], 2'b00};
                        mem_wmask   <= wmask;
                        mem_wdata   <= wdata_lane;
                        mem_read    <= !bad && !req_write;
                        mem_write   <= !bad && req_write;
                        resp_valid  <= bad;
                        state       <= bad ? DONE : BUSY;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_resp || (TIMEOUT > 0 && cnt == TMAX)) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= !mem_resp;
                        resp_rdata <= (mem_resp && !wr) ? rdata_ext : 32'd0;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_adapter.sv
// tb_mem_port_adapter: directed and random load/store transactions checked against a byte-level reference model.
module tb_mem_port_adapter;
    localparam int TMO = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_address, mem_wdata;
    logic        mem_read, mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_resp = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    mem_port_adapter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Access size in bytes; 0 marks a size code that does not exist.
    function automatic int unsigned size_of(input logic [2:0] f);
        case (f[1:0])
            2'd0: return 1;
            2'd1: return 2;
            2'd2: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_bad(input bit w, input logic [2:0] f, input logic [31:0] a);
        int unsigned s = size_of(f);
        if (s == 0 || f == 3'b110 || (w && f[2])) return 1'b1;
        return (a % s) != 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] a, input logic [31:0] word);
        longint unsigned wv = word;
        longint unsigned s = size_of(f);
        longint unsigned span = 64'd1 << (8 * s);
        longint unsigned v = (wv >> (8 * (a % 4))) % span;
        if (!f[2] && s < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic txn(input bit w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int dly);
        bit bad = is_bad(w, f, a);
        bit ok_resp = (dly >= 1 && dly <= TMO);
        int done = bad ? 1 : (ok_resp ? dly + 1 : TMO + 1);
        int last = (dly > done + 1) ? dly : done + 1;
        int waited = 0;
        int unsigned s = size_of(f);
        int unsigned o = a % 4;
        logic [3:0]  emask = 4'd0;
        logic [31:0] bm = 32'd0, ew = 32'd0;
        for (int j = 0; j < 4; j++)
            if (s != 0 && j >= o && j < o + s) begin
                emask[j] = 1'b1;
                bm[8*j +: 8] = 8'hFF;
                ew[8*j +: 8] = wd[8*(j-o) +: 8];
            end
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            mem_resp = (i == dly);
            mem_rdata = (i == dly) ? rd : $urandom;
            if (i < done) begin
                chk("busy_resp_valid", {31'd0, resp_valid}, 32'd0);
                chk("busy_mem_read", {31'd0, mem_read}, {31'd0, !w});
                chk("busy_mem_write", {31'd0, mem_write}, {31'd0, w});
                chk("busy_mem_address", mem_address, {a[31:2], 2'b00});
                chk("busy_wmask", {28'd0, mem_wmask}, w ? {28'd0, emask} : 32'd0);
                if (w) chk("busy_wdata", mem_wdata & bm, ew);
            end else if (i == done) begin
                chk("resp_valid", {31'd0, resp_valid}, 32'd1);
                chk("resp_err", {31'd0, resp_err}, {31'd0, bad || !ok_resp});
                chk("resp_rdata", resp_rdata, (bad || !ok_resp || w) ? 32'd0 : load_val(f, a, rd));
                chk("done_mem_read", {31'd0, mem_read}, 32'd0);
                chk("done_mem_write", {31'd0, mem_write}, 32'd0);
            end else begin
                chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
                chk("idle_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
                if (i == done + 1) chk("req_ready_after", {31'd0, req_ready}, 32'd1);
            end
        end
        @(negedge clk);
        mem_resp = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_wmask", {28'd0, mem_wmask}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        txn(0, 3'b010, 32'h4000_0008, 32'h0, 32'hDEAD_BEEF, 3);
        txn(0, 3'b000, 32'h1000_0003, 32'h0, 32'h8011_2233, 2);
        txn(0, 3'b100, 32'h1000_0003, 32'h0, 32'h8011_2233, 1);
        txn(0, 3'b101, 32'h1000_0002, 32'h0, 32'hBEEF_1234, 2);
        txn(0, 3'b001, 32'h1000_0002, 32'h0, 32'hBEEF_1234, 4);
        txn(1, 3'b000, 32'h2000_0001, 32'h0000_00AB, 32'h0, 3);
        txn(1, 3'b001, 32'h2000_0002, 32'h0000_ABCD, 32'h0, 2);
        txn(0, 3'b010, 32'h3000_0002, 32'h0, 32'h1234_5678, 1);
        txn(1, 3'b001, 32'h3000_0001, 32'h5555_5555, 32'h0, 1);
        txn(0, 3'b011, 32'h3000_0000, 32'h0, 32'h1111_1111, 1);
        txn(1, 3'b100, 32'h3000_0000, 32'h0000_00FF, 32'h0, 1);
        txn(0, 3'b010, 32'h5000_0010, 32'h0, 32'hCAFE_F00D, 11);
        txn(0, 3'b010, 32'h5000_0014, 32'h0, 32'h0BAD_CAFE, TMO);
        txn(1, 3'b010, 32'h5000_0018, 32'hA5A5_5A5A, 32'h0, 0);
        // Reset mid-transfer, with a second request held on req_valid during BUSY.
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0100;
        @(posedge clk);
        #1;
        req_addr = 32'h0000_0200;
        repeat (2) @(negedge clk);
        chk("busy_ignores_req_addr", mem_address, 32'h0000_0100);
        chk("busy_read_held", {31'd0, mem_read}, 32'd1);
        chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("midrst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        end
        for (int n = 0; n < 150; n++) begin
            logic [2:0] f = 3'($urandom_range(0, 7));
            bit w = 1'($urandom_range(0, 1));
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (size_of(f) == 4) ? 2'b00 : (size_of(f) == 2 ? {a[1], 1'b0} : a[1:0]);
            txn(w, f, a, $urandom, $urandom, $urandom_range(1, TMO + 3));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
